// File: rtl/enc_pkg.sv
// Shared definitions for the request index encoder.
//
// Contents:
//   enc_state_t   - two-state scan controller encoding (IDLE, SCAN)
//   ENC_N_DEFAULT - default request vector width
package enc_pkg;

  typedef enum logic {IDLE, SCAN} enc_state_t;

  localparam int ENC_N_DEFAULT = 8;

endpackage

// File: rtl/lowest_set_index.sv
// Combinational priority encoder.
// It returns the binary index of the lowest set bit of a vector.
//
// Ports:
//   vec    [N-1:0]     input  vector to inspect
//   idx    [IDX_W-1:0] index of lowest set bit, 0 when vec is all zero
//   any                at least one bit of vec is set
//   single             exactly one bit of vec is set
module lowest_set_index
  import enc_pkg::*;
#(
  parameter int N = ENC_N_DEFAULT,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             single
);

  // Walk from the top bit down to bit 0.
  // The last hit wins, so the lowest set bit ends up in idx.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  // vec & (vec - 1) clears the lowest set bit.
  // If nothing is left afterwards, exactly one bit was set.
  always_comb begin
    any    = |vec;
    single = any && ((vec & (vec - N'(1))) == '0);
  end

endmodule

// File: rtl/req_index_encoder.sv
// Sequential N-to-log2(N) encoder.
// It accepts a multi-hot request vector and streams out the index of every
// set bit, lowest first, one index per output handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   request vector presented on in_req
//   in_ready   block can accept a vector (IDLE and not in reset)
//   in_req     [N-1:0] multi-hot request vector
//   out_valid  out_idx holds a valid index
//   out_ready  consumer accepts the current index
//   out_idx    [IDX_W-1:0] index of lowest pending request
//   out_last   current beat is the final index of this vector
//   err_zero   one-cycle pulse after an all-zero vector was accepted
//   busy       scan in progress
module req_index_encoder
  import enc_pkg::*;
#(
  parameter int N = ENC_N_DEFAULT,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             err_zero,
  output logic             busy
);

  enc_state_t       state;
  enc_state_t       state_next;
  logic [N-1:0]     pending;
  logic [IDX_W-1:0] pend_idx;
  logic             pend_any;
  logic             pend_single;
  logic             in_fire;
  logic             out_fire;

  // Priority encoder on the registered pending mask.
  // out_idx therefore never depends combinationally on any input.
  lowest_set_index #(.N(N)) u_lsi (
    .vec    (pending),
    .idx    (pend_idx),
    .any    (pend_any),
    .single (pend_single)
  );

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // State register.
  // Reset drops straight back to IDLE, discarding any scan in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // A non-zero vector starts a scan. The scan ends on the handshake of the
  // final index. The pend_any escape keeps the FSM from getting stuck in
  // SCAN with nothing left to emit.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (in_fire && (in_req != '0)) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        if ((out_fire && out_last) || !pend_any) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending mask.
  // It is loaded on accept. One bit is retired per output handshake.
  // During a stall it holds, which keeps out_idx and out_last steady.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else if (state == IDLE) begin
      if (in_fire) begin
        pending <= in_req;
      end
    end else if (out_fire) begin
      pending <= pending & (pending - N'(1));
    end
  end

  // Zero-vector flag.
  // It is rewritten every cycle, so it is high for exactly one cycle after
  // an empty vector is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_zero <= 1'b0;
    end else begin
      err_zero <= in_fire && (in_req == '0);
    end
  end

  // Output decode.
  // in_ready is gated by rst so nothing is taken while reset is asserted.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == SCAN);
    busy      = (state == SCAN);
    out_idx   = pend_idx;
    out_last  = pend_single && (state == SCAN);
  end

endmodule

// File: tb/tb_req_index_encoder.sv
// Directed self-checking testbench for req_index_encoder (N = 8).
module tb_req_index_encoder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_req;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       err_zero;
  logic       busy;

  int tests;
  int failures;

  req_index_encoder #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_req    (in_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .err_zero  (err_zero),
    .busy      (busy)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  // Outputs are sampled there, and new inputs are driven there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Reset state while rst is held.
    step();
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_idx !== 3'd0 ||
        out_last !== 1'b0 || err_zero !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: got valid=%b busy=%b idx=%0d last=%b err=%b rdy=%b required 0 0 0 0 0 0",
               out_valid, busy, out_idx, out_last, err_zero, in_ready);
    end
    rst = 1'b0;
    step();
    tests++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release_ready: got %b required 1", in_ready);
    end
    // Start a scan, then assert reset mid-cycle with in_valid still high.
    in_valid = 1'b1;
    in_req   = 8'hFF;
    out_ready = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_prescan_valid: got %b required 1", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || err_zero !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_async: got valid=%b err=%b rdy=%b busy=%b required 0 0 0 0",
               out_valid, err_zero, in_ready, busy);
    end
    in_valid = 1'b0;
    in_req   = 8'h00;
    #1 rst = 1'b0;
    step();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_after_release: got rdy=%b valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_req    = 8'b0001_0000;
    step();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd4 || out_last !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_beat: got valid=%b idx=%0d last=%b rdy=%b required 1 4 1 0",
               out_valid, out_idx, out_last, in_ready);
    end
    step();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_done: got valid=%b rdy=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_multi_hot();
    int expIdx[4];
    expIdx = '{0, 2, 5, 7};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_req    = 8'b1010_0101;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (out_valid !== 1'b1 || out_idx !== 3'(expIdx[k]) ||
          out_last !== (k == 3) || in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL multi_beat%0d: got valid=%b idx=%0d last=%b rdy=%b required 1 %0d %b 0",
                 k, out_valid, out_idx, out_last, in_ready, expIdx[k], (k == 3));
      end
      step();
    end
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL multi_done: got valid=%b rdy=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_req    = 8'b1100_0000;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (out_valid !== 1'b1 || out_idx !== 3'd6 || out_last !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stall_hold%0d: got valid=%b idx=%0d last=%b required 1 6 0",
                 k, out_valid, out_idx, out_last);
      end
      step();
    end
    out_ready = 1'b1;
    tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd6 || out_last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_release6: got valid=%b idx=%0d last=%b required 1 6 0",
               out_valid, out_idx, out_last);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd7 || out_last !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_release7: got valid=%b idx=%0d last=%b required 1 7 1",
               out_valid, out_idx, out_last);
    end
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_done: got valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_zero_and_ignored();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_req    = 8'h00;
    step();
    in_valid = 1'b0;
    tests++;
    if (err_zero !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL zero_pulse: got err=%b valid=%b rdy=%b required 1 0 1",
               err_zero, out_valid, in_ready);
    end
    step();
    tests++;
    if (err_zero !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_clear: got err=%b valid=%b required 0 0", err_zero, out_valid);
    end
    // Accept 8'h01, then present 8'h80 while the scan is stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_req    = 8'h01;
    step();
    in_req = 8'h80;
    tests++;
    if (in_ready !== 1'b0 || out_idx !== 3'd0 || out_last !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ignore_scan: got rdy=%b idx=%0d last=%b required 0 0 1",
               in_ready, out_idx, out_last);
    end
    step();
    tests++;
    if (out_idx !== 3'd0 || out_last !== 1'b1 || err_zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ignore_hold: got idx=%0d last=%b err=%b required 0 1 0",
               out_idx, out_last, err_zero);
    end
    in_valid  = 1'b0;
    in_req    = 8'h00;
    out_ready = 1'b1;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ignore_done: got valid=%b required 0", out_valid);
    end
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ignore_no_extra: got valid=%b idx=%0d required valid 0", out_valid, out_idx);
    end
  endtask

  task automatic test_mid_scan_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_req    = 8'hFF;
    step();
    in_valid = 1'b0;
    in_req   = 8'h00;
    tests++;
    if (out_idx !== 3'd0 || out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_beat0: got valid=%b idx=%0d required 1 0", out_valid, out_idx);
    end
    step();
    tests++;
    if (out_idx !== 3'd1 || out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_beat1: got valid=%b idx=%0d required 1 1", out_valid, out_idx);
    end
    step();
    #2 rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_async: got valid=%b busy=%b required 0 0", out_valid, busy);
    end
    #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL midrst_residual%0d: got valid=%b idx=%0d rdy=%b required 0 x 1",
                 k, out_valid, out_idx, in_ready);
      end
    end
  endtask

  initial begin
    tests     = 0;
    failures  = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_req    = 8'h00;
    out_ready = 1'b0;
    #1 rst = 1'b1;
    test_reset();
    test_single();
    test_multi_hot();
    test_backpressure();
    test_zero_and_ignored();
    test_mid_scan_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
